// File: rtl/mcu_playlist.sv
// Playlist controller: turns button and song-completion pulses into play/pause,
// song index, playback mode and a one-cycle registered reset pulse for the player.
module mcu_playlist #(
    parameter int NUM_SONGS   = 4,
    parameter int SONG_W      = 2,
    parameter int PREV_WINDOW = 1000000,
    parameter int AUTO_PLAY   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        master_state,
    input  logic              play_button,
    input  logic              next_button,
    input  logic              prev_button,
    input  logic              mode_button,
    input  logic              song_done,
    output logic              play,
    output logic              reset_player,
    output logic [SONG_W-1:0] song,
    output logic [1:0]        mode
);

    localparam int EL_W = $clog2(PREV_WINDOW + 1);
    localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);
    localparam logic [EL_W-1:0]   WINDOW    = EL_W'(PREV_WINDOW);

    typedef enum logic [1:0] {
        S_AWAIT   = 2'd0,
        S_PLAY    = 2'd1,
        S_PAUSED  = 2'd2,
        S_ILLEGAL = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        M_NORMAL     = 2'd0,
        M_LOOP_ALL   = 2'd1,
        M_REPEAT_ONE = 2'd2,
        M_RSVD       = 2'd3
    } mode_e;

    localparam state_e AFTER_DONE = (AUTO_PLAY != 0) ? S_PLAY : S_AWAIT;

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [SONG_W-1:0] song_q, song_d;
    logic              rp_q, rp_d;
    logic [EL_W-1:0]   elapsed_q, elapsed_d;

    logic              active;
    logic              running;
    logic [SONG_W-1:0] song_inc;
    logic [SONG_W-1:0] song_dec;

    // Explicit compare-to-bound so non-power-of-two song counts wrap correctly.
    assign active   = (master_state == 2'b10);
    assign running  = (state_q == S_PLAY) || (state_q == S_PAUSED);
    assign song_inc = (song_q == LAST_SONG) ? '0 : song_q + 1'b1;
    assign song_dec = (song_q == '0) ? LAST_SONG : song_q - 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_AWAIT;
            mode_q    <= M_NORMAL;
            song_q    <= '0;
            rp_q      <= 1'b0;
            elapsed_q <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            song_q    <= song_d;
            rp_q      <= rp_d;
            elapsed_q <= elapsed_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        song_d    = song_q;
        rp_d      = 1'b0;
        elapsed_d = elapsed_q;
        if (active) begin
            if (mode_button) begin
                case (mode_q)
                    M_NORMAL:   mode_d = M_LOOP_ALL;
                    M_LOOP_ALL: mode_d = M_REPEAT_ONE;
                    default:    mode_d = M_NORMAL;
                endcase
            end
            // Only the highest-priority event acts: song_done > next > prev > play.
            if (state_q == S_ILLEGAL) begin
                state_d = S_AWAIT;
                song_d  = '0;
                rp_d    = 1'b1;
            end else if (song_done && running) begin
                rp_d = 1'b1;
                case (mode_q)
                    M_LOOP_ALL: begin
                        song_d  = song_inc;
                        state_d = AFTER_DONE;
                    end
                    M_REPEAT_ONE: state_d = AFTER_DONE;
                    default: begin
                        if (song_q == LAST_SONG) begin
                            song_d  = '0;
                            state_d = S_AWAIT;
                        end else begin
                            song_d  = song_inc;
                            state_d = AFTER_DONE;
                        end
                    end
                endcase
            end else if (next_button) begin
                song_d  = song_inc;
                state_d = S_AWAIT;
                rp_d    = running;
            end else if (prev_button) begin
                state_d = S_AWAIT;
                rp_d    = running;
                if (!(running && (elapsed_q >= WINDOW))) song_d = song_dec;
            end else if (play_button) begin
                case (state_q)
                    S_PLAY:  state_d = S_PAUSED;
                    default: state_d = S_PLAY;
                endcase
            end
            if ((song_d != song_q) || rp_d || (state_d == S_AWAIT)) begin
                elapsed_d = '0;
            end else if ((state_q == S_PLAY) && !rp_q && (elapsed_q != WINDOW)) begin
                elapsed_d = elapsed_q + 1'b1;
            end
        end
    end

    assign play         = active && (state_q == S_PLAY) && !rp_q;
    assign reset_player = active && rp_q;
    assign song         = song_q;
    assign mode         = mode_q;

endmodule
